// File: rtl/tap_pkg.sv
// Shared types and constants for the IR-capable JTAG TAP controller.
package tap_pkg;

  typedef enum logic [3:0] {
    StTlr   = 4'd0,
    StRti   = 4'd1,
    StSelDr = 4'd2,
    StCapDr = 4'd3,
    StShDr  = 4'd4,
    StEx1Dr = 4'd5,
    StPauDr = 4'd6,
    StEx2Dr = 4'd7,
    StUpdDr = 4'd8,
    StSelIr = 4'd9,
    StCapIr = 4'd10,
    StShIr  = 4'd11,
    StEx1Ir = 4'd12,
    StPauIr = 4'd13,
    StEx2Ir = 4'd14,
    StUpdIr = 4'd15
  } tap_state_e;

  // Data register currently placed between TDI and TDO.
  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrUser
  } dr_sel_e;

  // BYPASS is the all-ones opcode at whatever IR width is in use.
  localparam int unsigned OpIdcodeDefault = 1;
  localparam int unsigned OpUserDefault   = 2;
  localparam int unsigned IdcodeLen       = 32;
  localparam logic [1:0]  IrCapturePat    = 2'b01;

  function automatic logic is_shift_state(tap_state_e s);
    return (s == StShDr) || (s == StShIr);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus TMS-driven next-state logic.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state,
  output tap_state_e state_nxt
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = TMS ? StTlr   : StRti;
      StRti:   state_d = TMS ? StSelDr : StRti;
      StSelDr: state_d = TMS ? StSelIr : StCapDr;
      StCapDr: state_d = TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS ? StUpdDr : StPauDr;
      StPauDr: state_d = TMS ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS ? StSelDr : StRti;
      StSelIr: state_d = TMS ? StTlr   : StCapIr;
      StCapIr: state_d = TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS ? StUpdIr : StPauIr;
      StPauIr: state_d = TMS ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  assign state     = state_q;
  assign state_nxt = state_d;

endmodule

// File: rtl/tap_ctrl_ir.sv
// TAP controller with instruction register, BYPASS, IDCODE and one user DR.
// Define TAP_SHIFT_COUNT_EN to add the shift_cnt output.
module tap_ctrl_ir
  import tap_pkg::*;
#(
  parameter int unsigned IR_LEN     = 4,
  parameter int unsigned DR_LEN     = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int unsigned OP_IDCODE  = OpIdcodeDefault,
  parameter int unsigned OP_USER    = OpUserDefault
) (
  input  logic              clk,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_EN,
  output logic [3:0]        state_obs,
  output logic [IR_LEN-1:0] ir_out,
  input  logic [DR_LEN-1:0] user_dr_in,
  output logic [DR_LEN-1:0] user_dr_out,
`ifdef TAP_SHIFT_COUNT_EN
  output logic [15:0]       shift_cnt,
`endif
  output logic              user_dr_upd
);

  localparam logic [IR_LEN-1:0] OpIdcode  = IR_LEN'(OP_IDCODE);
  localparam logic [IR_LEN-1:0] OpUser    = IR_LEN'(OP_USER);
  localparam logic [IR_LEN-1:0] IrCapture = IR_LEN'(IrCapturePat);

  tap_state_e state, state_nxt;

  tap_fsm u_tap_fsm (
    .clk       (clk),
    .TRST      (TRST),
    .TMS       (TMS),
    .state     (state),
    .state_nxt (state_nxt)
  );

  logic [IR_LEN-1:0]    ir_sr_q, ir_sr_d;
  logic [IR_LEN-1:0]    ir_q, ir_d;
  logic                 bypass_q, bypass_d;
  logic [IdcodeLen-1:0] idcode_q, idcode_d;
  logic [DR_LEN-1:0]    user_sr_q, user_sr_d;
  logic [DR_LEN-1:0]    user_out_q, user_out_d;
  logic                 upd_q, upd_d;
  dr_sel_e              dr_sel;

  // Unknown opcodes fall back to BYPASS so the chain length stays defined.
  always_comb begin
    dr_sel = DrBypass;
    if (&ir_q) begin
      dr_sel = DrBypass;
    end else if (ir_q == OpIdcode) begin
      dr_sel = DrIdcode;
    end else if (ir_q == OpUser) begin
      dr_sel = DrUser;
    end
  end

  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    user_sr_d  = user_sr_q;
    user_out_d = user_out_q;
    upd_d      = 1'b0;

    case (state)
      StCapIr: ir_sr_d = IrCapture;
      StShIr: begin
        ir_sr_d             = ir_sr_q >> 1;
        ir_sr_d[IR_LEN-1]   = TDI;
      end
      StUpdIr: ir_d = ir_sr_q;
      StCapDr: begin
        case (dr_sel)
          DrIdcode: idcode_d  = IDCODE_VAL;
          DrUser:   user_sr_d = user_dr_in;
          default:  bypass_d  = 1'b0;
        endcase
      end
      StShDr: begin
        case (dr_sel)
          DrIdcode: begin
            idcode_d              = idcode_q >> 1;
            idcode_d[IdcodeLen-1] = TDI;
          end
          DrUser: begin
            user_sr_d             = user_sr_q >> 1;
            user_sr_d[DR_LEN-1]   = TDI;
          end
          default: bypass_d = TDI;
        endcase
      end
      StUpdDr: begin
        if (dr_sel == DrUser) begin
          user_out_d = user_sr_q;
          upd_d      = 1'b1;
        end
      end
      default: ;
    endcase

    // Any edge that lands in Test-Logic-Reset restores the IDCODE instruction.
    if (state_nxt == StTlr) begin
      ir_d = OpIdcode;
    end
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      ir_sr_q    <= '0;
      ir_q       <= OpIdcode;
      bypass_q   <= 1'b0;
      idcode_q   <= '0;
      user_sr_q  <= '0;
      user_out_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
      user_sr_q  <= user_sr_d;
      user_out_q <= user_out_d;
      upd_q      <= upd_d;
    end
  end

  always_comb begin
    TDO = 1'b0;
    case (state)
      StShIr: TDO = ir_sr_q[0];
      StShDr: begin
        case (dr_sel)
          DrIdcode: TDO = idcode_q[0];
          DrUser:   TDO = user_sr_q[0];
          default:  TDO = bypass_q;
        endcase
      end
      default: TDO = 1'b0;
    endcase
  end

`ifdef TAP_SHIFT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state == StCapDr) || (state == StCapIr)) begin
      cnt_d = '0;
    end else if (is_shift_state(state) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shift_cnt = cnt_q;
`endif

  assign TDO_EN      = is_shift_state(state);
  assign state_obs   = 4'(state);
  assign ir_out      = ir_q;
  assign user_dr_out = user_out_q;
  assign user_dr_upd = upd_q;

endmodule

// File: tb/tb_tap_ctrl_ir.sv
// Bench for tap_ctrl_ir: directed scans plus random TMS/TDI against a behavioural model.
module tb_tap_ctrl_ir;

  logic       clk = 1'b0;
  logic       TRST = 1'b1;
  logic       TMS = 1'b0;
  logic       TDI = 1'b0;
  logic       TDO, TDO_EN, user_dr_upd;
  logic [3:0] state_obs, ir_out;
  logic [7:0] user_dr_in = 8'h00;
  logic [7:0] user_dr_out;
`ifdef TAP_SHIFT_COUNT_EN
  logic [15:0] shift_cnt;
`endif

  tap_ctrl_ir dut (
    .clk         (clk),
    .TRST        (TRST),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .TDO_EN      (TDO_EN),
    .state_obs   (state_obs),
    .ir_out      (ir_out),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
`ifdef TAP_SHIFT_COUNT_EN
    .shift_cnt   (shift_cnt),
`endif
    .user_dr_upd (user_dr_upd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Transition graph as lookup tables indexed by state code: n0 for TMS=0, n1 for TMS=1.
  int n0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int n1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          ms;
  logic [3:0]  mir_sr, mir;
  logic        mbp;
  logic [31:0] mid;
  logic [7:0]  musr, mout;
  logic        mupd;
  logic [15:0] mcnt;

  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int msel();
    if (mir == 4'hF) return 0;
    if (mir == 4'h1) return 1;
    if (mir == 4'h2) return 2;
    return 0;
  endfunction

  function automatic logic m_tdo();
    int s;
    if (ms == 11) return mir_sr[0];
    if (ms != 4) return 1'b0;
    s = msel();
    if (s == 1) return mid[0];
    if (s == 2) return musr[0];
    return mbp;
  endfunction

  task automatic model_step(input logic tms, input logic tdi, input logic trst);
    int s;
    if (trst) begin
      ms = 0; mir_sr = 0; mir = 4'h1; mbp = 0; mid = 0; musr = 0; mout = 0; mupd = 0; mcnt = 0;
      return;
    end
    s    = msel();
    mupd = 1'b0;
    if (ms == 10 || ms == 3) mcnt = 0;
    if ((ms == 11 || ms == 4) && mcnt != 16'hFFFF) mcnt = mcnt + 1;
    if (ms == 10) mir_sr = 4'b0001;
    if (ms == 11) mir_sr = (mir_sr >> 1) | (4'(tdi) << 3);
    if (ms == 3) begin
      if (s == 1) mid = 32'h1234_5679;
      else if (s == 2) musr = user_dr_in;
      else mbp = 1'b0;
    end
    if (ms == 4) begin
      if (s == 1) mid = (mid >> 1) | (32'(tdi) << 31);
      else if (s == 2) musr = (musr >> 1) | (8'(tdi) << 7);
      else mbp = tdi;
    end
    if (ms == 15) mir = mir_sr;
    if (ms == 8 && s == 2) begin
      mout = musr;
      mupd = 1'b1;
    end
    ms = tms ? n1[ms] : n0[ms];
    if (ms == 0) mir = 4'h1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic tms, input logic tdi, input logic trst);
    TMS  = tms;
    TDI  = tdi;
    TRST = trst;
    @(posedge clk);
    model_step(tms, tdi, trst);
    #1;
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < len; i++) begin
      dout[i] = TDO;
      cyc(i == len - 1, din[i], 0);
    end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic scan_ir(input int len, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < len; i++) begin
      dout[i] = TDO;
      cyc(i == len - 1, din[i], 0);
    end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("state_obs", 64'(state_obs), 64'(ms));
        chk("TDO", 64'(TDO), 64'(m_tdo()));
        chk("TDO_EN", 64'(TDO_EN), 64'(ms == 4 || ms == 11));
        chk("ir_out", 64'(ir_out), 64'(mir));
        chk("user_dr_out", 64'(user_dr_out), 64'(mout));
        chk("user_dr_upd", 64'(user_dr_upd), 64'(mupd));
`ifdef TAP_SHIFT_COUNT_EN
        chk("shift_cnt", 64'(shift_cnt), 64'(mcnt));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got;

    cyc(0, 0, 1);
    armed = 1'b1;
    chk("reset state", 64'(state_obs), 64'd0);
    chk("reset ir_out", 64'(ir_out), 64'h1);
    chk("reset user_dr_out", 64'(user_dr_out), 64'h0);
    chk("reset TDO_EN", 64'(TDO_EN), 64'h0);
    chk("reset TDO", 64'(TDO), 64'h0);

    cyc(0, 0, 0);
    chk("rti after reset", 64'(state_obs), 64'd1);

    scan_dr(32, 64'h0, got);
    chk("idcode read", got & 64'hFFFF_FFFF, 64'h1234_5679);

    scan_ir(4, 64'hF, got);
    chk("ir capture", got & 64'hF, 64'h1);
    chk("ir update", 64'(ir_out), 64'hF);

    scan_dr(4, 64'b1101, got);
    chk("bypass delay", got & 64'hF, 64'b1010);

    scan_ir(4, 64'h2, got);
    chk("ir user", 64'(ir_out), 64'h2);
    user_dr_in = 8'h3C;
    scan_dr(8, 64'hA5, got);
    chk("user capture", got & 64'hFF, 64'h3C);
    chk("user update", 64'(user_dr_out), 64'hA5);
    chk("user upd pulse", 64'(user_dr_upd), 64'h1);
`ifdef TAP_SHIFT_COUNT_EN
    chk("shift count", 64'(shift_cnt), 64'd8);
`endif
    cyc(0, 0, 0);
    chk("user upd one cycle", 64'(user_dr_upd), 64'h0);

    // Reset in the middle of a USER shift.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("in shdr", 64'(state_obs), 64'd4);
    cyc(0, 0, 1);
    chk("midshift reset state", 64'(state_obs), 64'd0);
    chk("midshift reset ir", 64'(ir_out), 64'h1);
    chk("midshift reset udr", 64'(user_dr_out), 64'h0);
    chk("midshift reset TDO_EN", 64'(TDO_EN), 64'h0);

    // Five TMS=1 from Shift-IR must land in Test-Logic-Reset and restore IDCODE.
    cyc(0, 0, 0);
    scan_ir(4, 64'hF, got);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("in shir", 64'(state_obs), 64'd11);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("tms reset state", 64'(state_obs), 64'd0);
    chk("tms reset ir", 64'(ir_out), 64'h1);
    cyc(0, 0, 0);
    chk("tms reset to rti", 64'(state_obs), 64'd1);

    for (int i = 0; i < 4000; i++) begin
      user_dr_in = 8'($urandom);
      cyc($urandom_range(0, 99) < 35, 1'($urandom), $urandom_range(0, 199) == 0);
    end

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
